modexp_ctrl: RTL and testbench

- Left-to-right square-and-multiply sequencer for modular exponentiation; sits directly upstream of the montgomery multiplier and drives it through its start/done handshake.
- Computes A = X^E in the Montgomery domain from a caller-supplied base X (already in Montgomery form) and one R mod M.
- Result is fed back to the multiplier's operand ports for every step. It feeds the RSA top level, which handles operand/result transfer.

---
 rtl/modexp_ctrl.sv | 244 ++++++++++++++++++++++++
 tb/tb_modexp_ctrl.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/modexp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : modexp_ctrl
// Purpose  : Left-to-right square-and-multiply sequencer for modular
//            exponentiation in the Montgomery domain. Drives an external
//            Montgomery multiplier through its start/done handshake and
//            computes A = X^E with X and A in Montgomery form.
// Options  : MODEXP_POSTCONV_EN - when defined, one extra multiplication by
//            plain 1 converts the final A out of the Montgomery domain.
// Revision : 1.0 - initial release
// ============================================================================
module modexp_ctrl #(
  parameter int DATA_W = 1024,
  parameter int ELEN_W = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] in_x,
  input  logic [DATA_W-1:0] in_e,
  input  logic [ELEN_W-1:0] in_e_len,
  input  logic [DATA_W-1:0] in_m,
  input  logic [DATA_W-1:0] in_r,
  output logic [DATA_W-1:0] result,
  output logic              done,
  output logic              busy,
  output logic              mm_start,
  output logic [DATA_W-1:0] mm_a,
  output logic [DATA_W-1:0] mm_b,
  output logic [DATA_W-1:0] mm_m,
  input  logic [DATA_W-1:0] mm_result,
  input  logic              mm_done
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_LOAD     = 4'd1,
    S_SQ_GO    = 4'd2,
    S_SQ_WAIT  = 4'd3,
    S_MUL_GO   = 4'd4,
    S_MUL_WAIT = 4'd5,
    S_FINISH   = 4'd6
`ifdef MODEXP_POSTCONV_EN
    ,
    S_CONV_GO   = 4'd7,
    S_CONV_WAIT = 4'd8
`endif
  } state_t;

  // Where the sequencer goes once the last exponent bit has been consumed
`ifdef MODEXP_POSTCONV_EN
  localparam state_t C_LAST_NEXT = S_CONV_GO;
`else
  localparam state_t C_LAST_NEXT = S_FINISH;
`endif

  localparam logic [ELEN_W-1:0] C_MAX_LEN = ELEN_W'(DATA_W);
  localparam logic [ELEN_W-1:0] C_ELEN_ONE = ELEN_W'(1);
`ifdef MODEXP_POSTCONV_EN
  localparam logic [DATA_W-1:0] C_ONE = DATA_W'(1);
`endif

  state_t            state_q, state_d;
  logic [DATA_W-1:0] x_q, x_d;
  logic [DATA_W-1:0] e_q, e_d;
  logic [DATA_W-1:0] m_q, m_d;
  logic [DATA_W-1:0] r_q, r_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [ELEN_W-1:0] elen_q, elen_d;
  logic [ELEN_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [DATA_W-1:0] mm_a_q, mm_a_d;
  logic [DATA_W-1:0] mm_b_q, mm_b_d;
  logic [DATA_W-1:0] mm_m_q, mm_m_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              mm_start_q, mm_start_d;

  // Current exponent bit, selected by shifting so any index width is legal
  logic [DATA_W-1:0] e_shift;
  logic              e_bit;
  logic              idx_zero;

  assign e_shift  = e_q >> idx_q;
  assign e_bit    = e_shift[0];
  assign idx_zero = (idx_q == '0);

  // Next-state and next-output computation for the square-and-multiply walk
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    e_d        = e_q;
    m_d        = m_q;
    r_d        = r_q;
    a_d        = a_q;
    elen_d     = elen_q;
    idx_d      = idx_q;
    result_d   = result_q;
    mm_a_d     = mm_a_q;
    mm_b_d     = mm_b_q;
    mm_m_d     = mm_m_q;
    mm_start_d = 1'b0;
    done_d     = 1'b0;
    busy_d     = busy_q;

    // busy stays high through the cycle in which done is shown
    if (done_q) begin
      busy_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        // busy_q is still high during the done cycle, so a start there is ignored
        if (start && !busy_q) begin
          x_d     = in_x;
          e_d     = in_e;
          m_d     = in_m;
          r_d     = in_r;
          elen_d  = (in_e_len > C_MAX_LEN) ? C_MAX_LEN : in_e_len;
          busy_d  = 1'b1;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        a_d = r_q;
        if (elen_q == '0) begin
          state_d = C_LAST_NEXT;
        end else begin
          idx_d   = elen_q - C_ELEN_ONE;
          state_d = S_SQ_GO;
        end
      end
      S_SQ_GO: begin
        mm_a_d     = a_q;
        mm_b_d     = a_q;
        mm_m_d     = m_q;
        mm_start_d = 1'b1;
        state_d    = S_SQ_WAIT;
      end
      S_SQ_WAIT: begin
        if (mm_done) begin
          a_d = mm_result;
          if (e_bit) begin
            state_d = S_MUL_GO;
          end else if (idx_zero) begin
            state_d = C_LAST_NEXT;
          end else begin
            idx_d   = idx_q - C_ELEN_ONE;
            state_d = S_SQ_GO;
          end
        end
      end
      S_MUL_GO: begin
        mm_a_d     = a_q;
        mm_b_d     = x_q;
        mm_m_d     = m_q;
        mm_start_d = 1'b1;
        state_d    = S_MUL_WAIT;
      end
      S_MUL_WAIT: begin
        if (mm_done) begin
          a_d = mm_result;
          if (idx_zero) begin
            state_d = C_LAST_NEXT;
          end else begin
            idx_d   = idx_q - C_ELEN_ONE;
            state_d = S_SQ_GO;
          end
        end
      end
`ifdef MODEXP_POSTCONV_EN
      S_CONV_GO: begin
        // Multiplying by plain 1 strips the R factor
        mm_a_d     = a_q;
        mm_b_d     = C_ONE;
        mm_m_d     = m_q;
        mm_start_d = 1'b1;
        state_d    = S_CONV_WAIT;
      end
      S_CONV_WAIT: begin
        if (mm_done) begin
          a_d     = mm_result;
          state_d = S_FINISH;
        end
      end
`endif
      S_FINISH: begin
        result_d = a_q;
        done_d   = 1'b1;
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered outputs, all cleared by synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      x_q        <= '0;
      e_q        <= '0;
      m_q        <= '0;
      r_q        <= '0;
      a_q        <= '0;
      elen_q     <= '0;
      idx_q      <= '0;
      result_q   <= '0;
      mm_a_q     <= '0;
      mm_b_q     <= '0;
      mm_m_q     <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      mm_start_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      e_q        <= e_d;
      m_q        <= m_d;
      r_q        <= r_d;
      a_q        <= a_d;
      elen_q     <= elen_d;
      idx_q      <= idx_d;
      result_q   <= result_d;
      mm_a_q     <= mm_a_d;
      mm_b_q     <= mm_b_d;
      mm_m_q     <= mm_m_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      mm_start_q <= mm_start_d;
    end
  end

  assign result   = result_q;
  assign done     = done_q;
  assign busy     = busy_q;
  assign mm_start = mm_start_q;
  assign mm_a     = mm_a_q;
  assign mm_b     = mm_b_q;
  assign mm_m     = mm_m_q;

endmodule
`default_nettype wire

// File: tb/tb_modexp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_modexp_ctrl
// Purpose  : Self-checking bench for modexp_ctrl at DATA_W=8 with a
//            behavioural Montgomery multiplier of random latency.
// Revision : 1.0 - initial release
// ============================================================================
module tb_modexp_ctrl;

  localparam int DW = 8;
  localparam int EW = 4;
`ifdef MODEXP_POSTCONV_EN
  localparam int PC = 1;
`else
  localparam int PC = 0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [DW-1:0] in_x = '0, in_e = '0, in_m = '0, in_r = '0;
  logic [EW-1:0] in_e_len = '0;
  logic [DW-1:0] result, mm_a, mm_b, mm_m;
  logic          done, busy, mm_start;
  logic [DW-1:0] mm_result = '0;
  logic          mm_done;
  logic          mm_done_model = 1'b0;
  logic          mm_done_tb = 1'b0;

  int checks = 0;
  int failures = 0;

  // multiplier model controls and state
  int   lat_min = 1;
  int   lat_max = 4;
  bit   mm_abort = 1'b1;
  bit   mm_pending = 1'b0;
  int   mm_cnt = 0;
  int   pulse_cnt = 0;
  int   cur_m = 0;
  logic [DW-1:0] op_a, op_b, op_m;

  assign mm_done = mm_done_model | mm_done_tb;

  always #5 clk = ~clk;

  modexp_ctrl #(.DATA_W(DW), .ELEN_W(EW)) dut (
    .clk(clk), .reset(reset), .start(start),
    .in_x(in_x), .in_e(in_e), .in_e_len(in_e_len), .in_m(in_m), .in_r(in_r),
    .result(result), .done(done), .busy(busy),
    .mm_start(mm_start), .mm_a(mm_a), .mm_b(mm_b), .mm_m(mm_m),
    .mm_result(mm_result), .mm_done(mm_done)
  );

  // ---------------- reference arithmetic ----------------
  function automatic int rinv_of(int m);
    for (int i = 1; i < m; i++) if (((256 * i) % m) == 1) return i;
    return 0;
  endfunction

  function automatic int mont(int a, int b, int m);
    longint t;
    t = (longint'(a) * b) % m;
    t = (t * rinv_of(m)) % m;
    return int'(t);
  endfunction

  function automatic int eff_len(int el);
    return (el > DW) ? DW : el;
  endfunction

  function automatic int exp_val(int e, int el);
    return e & ((1 << eff_len(el)) - 1);
  endfunction

  // plain x^E mod m, re-encoded to Montgomery form unless post-conversion is on
  function automatic int ref_result(int x, int e, int el, int m);
    longint xp, p;
    int ev;
    xp = (longint'(x) * rinv_of(m)) % m;
    ev = exp_val(e, el);
    p  = 1 % m;
    for (int i = 0; i < ev; i++) p = (p * xp) % m;
    if (PC == 1) return int'(p);
    return int'((p * 256) % m);
  endfunction

  function automatic int ref_pulses(int e, int el);
    return eff_len(el) + $countones(exp_val(e, el)) + PC;
  endfunction

  // ---------------- multiplier model ----------------
  always @(negedge clk) begin
    mm_done_model = 1'b0;
    if (mm_abort) begin
      mm_pending = 1'b0;
    end else begin
      if (mm_pending) begin
        checks++;
        if (mm_a !== op_a || mm_b !== op_b || mm_m !== op_m) begin
          failures++;
          $display("FAIL operand_stable a=%h b=%h m=%h required a=%h b=%h m=%h",
                   mm_a, mm_b, mm_m, op_a, op_b, op_m);
        end
        mm_cnt--;
        if (mm_cnt <= 0) begin
          mm_result     = DW'(mont(int'(op_a), int'(op_b), int'(op_m)));
          mm_done_model = 1'b1;
          mm_pending    = 1'b0;
        end
      end
      if (mm_start === 1'b1) begin
        pulse_cnt++;
        checks++;
        if (mm_pending) begin
          failures++;
          $display("FAIL mm_start_outstanding pending=1 required pending=0");
        end
        checks++;
        if (mm_m !== DW'(cur_m)) begin
          failures++;
          $display("FAIL mm_m_value got=%h required=%h", mm_m, DW'(cur_m));
        end
        op_a       = mm_a;
        op_b       = mm_b;
        op_m       = mm_m;
        mm_pending = 1'b1;
        mm_cnt     = $urandom_range(lat_max, lat_min);
      end
    end
  end

  // ---------------- scenario helpers ----------------
  // One operation: start, optional re-pulse of start at cycle glitch, wait done
  task automatic run_op(input int x, input int e, input int el, input int m,
                        input int glitch, output int res, output int pulses,
                        output int dcyc);
    int p0, cyc, limit;
    bit seen;
    limit = 20 * (lat_max + 3) + 20;
    cur_m = m;
    @(negedge clk);
    in_x = DW'(x); in_e = DW'(e); in_e_len = EW'(el); in_m = DW'(m);
    in_r = DW'(256 % m);
    start = 1'b1;
    p0 = pulse_cnt;
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < limit) begin
      @(negedge clk);
      cyc++;
      start = (cyc == glitch);
      if (cyc == 1 || cyc == glitch) begin
        in_x = DW'($urandom); in_e = DW'($urandom); in_r = DW'($urandom);
        in_e_len = EW'($urandom);
      end
      if (done === 1'b1) seen = 1'b1;
    end
    start = 1'b0;
    dcyc = cyc;
    res = int'(result);
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL done_timeout cycles=%0d required done within %0d", cyc, limit);
    end else begin
      checks++;
      if (busy !== 1'b1) begin
        failures++;
        $display("FAIL busy_in_done_cycle got=%b required=1", busy);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL after_done done=%b busy=%b required 0 0", done, busy);
      end
    end
    pulses = pulse_cnt - p0;
  endtask

  task automatic check_op(input string name, input int x, input int e, input int el,
                          input int m, input int glitch);
    int res, pulses, dcyc, er, ep;
    run_op(x, e, el, m, glitch, res, pulses, dcyc);
    er = ref_result(x, e, el, m);
    ep = ref_pulses(e, el);
    checks++;
    if (res != er) begin
      failures++;
      $display("FAIL %s_result x=%0d e=%0d len=%0d m=%0d got=%0d required=%0d",
               name, x, e, el, m, res, er);
    end
    checks++;
    if (pulses != ep) begin
      failures++;
      $display("FAIL %s_pulses got=%0d required=%0d", name, pulses, ep);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; mm_abort = 1'b1; start = 1'b0; mm_done_tb = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    mm_abort = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    checks++;
    if (result !== '0 || done !== 1'b0 || busy !== 1'b0 || mm_start !== 1'b0 ||
        mm_a !== '0 || mm_b !== '0 || mm_m !== '0) begin
      failures++;
      $display("FAIL reset_values result=%h done=%b busy=%b mm_start=%b a=%h b=%h m=%h required all 0",
               result, done, busy, mm_start, mm_a, mm_b, mm_m);
    end
  endtask

  task automatic test_example();
    int res, pulses, dcyc;
    lat_min = 1; lat_max = 5;
    run_op(5, 5, 3, 13, -1, res, pulses, dcyc);
    checks++;
    if (res != ((PC == 1) ? 6 : 2)) begin
      failures++;
      $display("FAIL example_result got=%0d required=%0d", res, (PC == 1) ? 6 : 2);
    end
    checks++;
    if (pulses != 5 + PC) begin
      failures++;
      $display("FAIL example_pulses got=%0d required=%0d", pulses, 5 + PC);
    end
  endtask

  task automatic test_zero_len();
    int res, pulses, dcyc;
    run_op(7, 200, 0, 13, -1, res, pulses, dcyc);
    checks++;
    if (res != ((PC == 1) ? 1 : 9)) begin
      failures++;
      $display("FAIL zero_len_result got=%0d required=%0d", res, (PC == 1) ? 1 : 9);
    end
    checks++;
    if (pulses != PC) begin
      failures++;
      $display("FAIL zero_len_pulses got=%0d required=%0d", pulses, PC);
    end
    if (PC == 0) begin
      checks++;
      if (dcyc != 3) begin
        failures++;
        $display("FAIL zero_len_latency got=%0d required=3", dcyc);
      end
    end
  endtask

  task automatic test_clamp();
    lat_min = 1; lat_max = 3;
    check_op("clamp", 3, 8'hB5, 15, 251, -1);
    check_op("full_len", 10, 8'hFF, 8, 17, -1);
  endtask

  task automatic test_random();
    int m, x, e, el;
    for (int i = 0; i < 30; i++) begin
      m = 2 * $urandom_range(127, 1) + 1;
      x = $urandom_range(m - 1, 0);
      e = $urandom_range(255, 0);
      el = $urandom_range(15, 0);
      lat_min = 1; lat_max = $urandom_range(6, 1);
      check_op("random", x, e, el, m, -1);
    end
  endtask

  task automatic test_start_ignored();
    lat_min = 10; lat_max = 10;
    check_op("start_ignored", 4, 6, 3, 29, 5);
    lat_min = 1; lat_max = 4;
  endtask

  task automatic test_reset_abort();
    int p0, guard, res, pulses, dcyc, er;
    lat_min = 20; lat_max = 20;
    cur_m = 23;
    @(negedge clk);
    in_x = 8'd5; in_e = 8'd7; in_e_len = 4'd3; in_m = 8'd23; in_r = DW'(256 % 23);
    start = 1'b1;
    p0 = pulse_cnt;
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (pulse_cnt < p0 + 2 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (pulse_cnt < p0 + 2) begin
      failures++;
      $display("FAIL abort_reach_mul pulses=%0d required=2", pulse_cnt - p0);
    end
    repeat (3) @(negedge clk);
    reset = 1'b1; mm_abort = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (result !== '0 || done !== 1'b0 || busy !== 1'b0 || mm_start !== 1'b0 ||
        mm_a !== '0 || mm_b !== '0 || mm_m !== '0) begin
      failures++;
      $display("FAIL abort_reset_values result=%h done=%b busy=%b mm_start=%b a=%h b=%h m=%h required all 0",
               result, done, busy, mm_start, mm_a, mm_b, mm_m);
    end
    repeat (2) @(negedge clk);
    mm_abort = 1'b0;
    repeat (2) @(negedge clk);
    mm_result = 8'hA5;
    mm_done_tb = 1'b1;
    @(negedge clk);
    mm_done_tb = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || mm_start !== 1'b0) begin
        failures++;
        $display("FAIL stale_done_ignored busy=%b done=%b mm_start=%b required 0 0 0",
                 busy, done, mm_start);
      end
    end
    lat_min = 1; lat_max = 4;
    run_op(5, 7, 3, 23, -1, res, pulses, dcyc);
    er = ref_result(5, 7, 3, 23);
    checks++;
    if (res != er) begin
      failures++;
      $display("FAIL abort_fresh_result got=%0d required=%0d", res, er);
    end
  endtask

  task automatic test_latency();
    int m, x, e, el, r1, p1, r2, p2, d;
    for (int i = 0; i < 2; i++) begin
      m = 2 * $urandom_range(127, 1) + 1;
      x = $urandom_range(m - 1, 0);
      e = $urandom_range(255, 0);
      el = $urandom_range(4, 1);
      lat_min = 1; lat_max = 1;
      run_op(x, e, el, m, -1, r1, p1, d);
      lat_min = 1; lat_max = 1100;
      run_op(x, e, el, m, -1, r2, p2, d);
      checks++;
      if (r2 != r1 || p2 != p1 || r2 != ref_result(x, e, el, m)) begin
        failures++;
        $display("FAIL latency_invariance fast=%0d/%0d slow=%0d/%0d required=%0d/%0d",
                 r1, p1, r2, p2, ref_result(x, e, el, m), ref_pulses(e, el));
      end
    end
    lat_min = 1; lat_max = 4;
  endtask

  task automatic test_back_to_back();
    lat_min = 1; lat_max = 2;
    check_op("b2b_first", 9, 8'b1011, 4, 101, -1);
    check_op("b2b_second", 50, 8'hC3, 8, 211, -1);
  endtask

  initial begin
    test_reset();
    test_example();
    test_zero_len();
    test_clamp();
    test_random();
    test_start_ignored();
    test_reset_abort();
    test_latency();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout time=%0t required completion before 900000", $time);
    $fatal(1, "global timeout");
  end

endmodule
`default_nettype wire
